// File: rtl/hls_fp17_mul_core_flow_ctrl.sv
// Flow/stall controller for the fp17 multiplier core: operand join,
// valid tracking through the core pipeline, backpressure and drain.
module hls_fp17_mul_core_flow_ctrl #(
  parameter  int LAT  = 3,
  parameter  int CNTW = 32,
  localparam int IW   = $clog2(LAT + 1)
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rstn,
  input  logic            chn_a_vld,
  output logic            chn_a_rdy,
  input  logic            chn_b_vld,
  output logic            chn_b_rdy,
  output logic            chn_o_vld,
  input  logic            chn_o_rdy,
  output logic            core_wen,
  output logic            core_wten,
  output logic            issue,
  input  logic            flush_req,
  output logic            flush_done,
  output logic [IW-1:0]   inflight,
  output logic [CNTW-1:0] op_cnt,
  output logic            idle
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    DONE
  } state_t;

  state_t         state;
  logic [LAT-1:0] pv;
  logic           retire;
  logic [IW-1:0]  inflight_nxt;

  assign chn_o_vld = pv[LAT-1];
  assign core_wen  = ~(pv[LAT-1] & ~chn_o_rdy);
  assign issue     = chn_a_vld & chn_b_vld & core_wen
                   & (state != DRAIN);
  assign chn_a_rdy = issue;
  assign chn_b_rdy = issue;
  assign retire    = pv[LAT-1] & chn_o_rdy;
  assign idle      = (state == IDLE) && (inflight == '0);

  always_comb begin
    inflight_nxt = inflight + IW'(issue) - IW'(retire);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      pv         <= '0;
      inflight   <= '0;
      op_cnt     <= '0;
      core_wten  <= 1'b1;
      flush_done <= 1'b0;
      state      <= IDLE;
    end else begin
      // the retiring result falls off the top when the pipe advances
      if (core_wen)
        pv <= (pv << 1) | LAT'(issue);
      inflight   <= inflight_nxt;
      if (issue)
        op_cnt <= op_cnt + CNTW'(1);
      core_wten  <= ~core_wen;
      flush_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_req) begin
            if (issue) begin
              state <= DRAIN;
            end else begin
              state      <= DONE;
              flush_done <= 1'b1;
            end
          end else if (issue) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (flush_req)
            state <= DRAIN;
          else if (inflight_nxt == '0 && !issue)
            state <= IDLE;
        end
        DRAIN: begin
          if (inflight == '0) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state <= issue ? BUSY : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_fp17_mul_core_flow_ctrl.sv
// Directed bench for the fp17 multiplier flow controller (LAT=3, CNTW=4).
module tb_hls_fp17_mul_core_flow_ctrl;

  localparam int LAT  = 3;
  localparam int CNTW = 4;
  localparam int IW   = $clog2(LAT + 1);

  logic            clk = 1'b0;
  logic            rstn;
  logic            a_vld, b_vld, o_rdy, flush;
  logic            a_rdy, b_rdy, o_vld;
  logic            wen, wten, iss, fdone, idl;
  logic [IW-1:0]   inf;
  logic [CNTW-1:0] cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hls_fp17_mul_core_flow_ctrl #(.LAT(LAT), .CNTW(CNTW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .chn_a_vld      (a_vld),
    .chn_a_rdy      (a_rdy),
    .chn_b_vld      (b_vld),
    .chn_b_rdy      (b_rdy),
    .chn_o_vld      (o_vld),
    .chn_o_rdy      (o_rdy),
    .core_wen       (wen),
    .core_wten      (wten),
    .issue          (iss),
    .flush_req      (flush),
    .flush_done     (fdone),
    .inflight       (inf),
    .op_cnt         (cnt),
    .idle           (idl)
  );

  typedef struct {
    logic a, b, r, f;
    logic e_iss, e_ovld, e_wen, e_wten, e_fd, e_idle;
    int   e_inf, e_cnt;
  } vec_t;

  vec_t v[30];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // a b r f | iss ovld wen wten fd idle | inflight op_cnt
    v[0]  = '{1,1,1,0, 1,0,1,1,0,1, 0,0};
    v[1]  = '{1,1,1,0, 1,0,1,0,0,0, 1,1};
    v[2]  = '{1,1,1,0, 1,0,1,0,0,0, 2,2};
    v[3]  = '{1,1,1,0, 1,1,1,0,0,0, 3,3};
    v[4]  = '{1,1,1,0, 1,1,1,0,0,0, 3,4};
    v[5]  = '{1,1,0,0, 0,1,0,0,0,0, 3,5};
    v[6]  = '{1,1,0,0, 0,1,0,1,0,0, 3,5};
    v[7]  = '{1,1,0,0, 0,1,0,1,0,0, 3,5};
    v[8]  = '{1,1,0,0, 0,1,0,1,0,0, 3,5};
    v[9]  = '{1,1,1,0, 1,1,1,1,0,0, 3,5};
    v[10] = '{1,0,1,0, 0,1,1,0,0,0, 3,6};
    v[11] = '{1,0,1,0, 0,1,1,0,0,0, 2,6};
    v[12] = '{1,0,1,0, 0,1,1,0,0,0, 1,6};
    v[13] = '{1,0,1,0, 0,0,1,0,0,1, 0,6};
    v[14] = '{1,0,1,0, 0,0,1,0,0,1, 0,6};
    v[15] = '{1,1,1,0, 1,0,1,0,0,1, 0,6};
    v[16] = '{0,0,1,0, 0,0,1,0,0,0, 1,7};
    v[17] = '{0,0,1,0, 0,0,1,0,0,0, 1,7};
    v[18] = '{0,0,1,0, 0,1,1,0,0,0, 1,7};
    v[19] = '{0,0,1,0, 0,0,1,0,0,1, 0,7};
    v[20] = '{1,1,1,0, 1,0,1,0,0,1, 0,7};
    v[21] = '{1,1,1,0, 1,0,1,0,0,0, 1,8};
    v[22] = '{1,1,1,1, 1,0,1,0,0,0, 2,9};
    v[23] = '{1,1,1,1, 0,1,1,0,0,0, 3,10};
    v[24] = '{1,1,1,1, 0,1,1,0,0,0, 2,10};
    v[25] = '{1,1,1,1, 0,1,1,0,0,0, 1,10};
    v[26] = '{1,1,1,1, 0,0,1,0,0,0, 0,10};
    v[27] = '{0,0,1,0, 0,0,1,0,1,0, 0,10};
    v[28] = '{1,1,1,0, 1,0,1,0,0,1, 0,10};
    v[29] = '{0,0,1,0, 0,0,1,0,0,0, 1,11};

    rstn  = 1'b0;
    a_vld = 1'b0;
    b_vld = 1'b0;
    o_rdy = 1'b1;
    flush = 1'b0;
    tick();
    tick();
    chk("rst_o_vld", o_vld, 0);
    chk("rst_wen", wen, 1);
    chk("rst_wten", wten, 1);
    chk("rst_rdy", a_rdy | b_rdy, 0);
    chk("rst_inflight", inf, 0);
    chk("rst_op_cnt", cnt, 0);
    chk("rst_flush_done", fdone, 0);
    chk("rst_idle", idl, 1);
    rstn = 1'b1;

    for (int i = 0; i < 30; i++) begin
      a_vld = v[i].a;
      b_vld = v[i].b;
      o_rdy = v[i].r;
      flush = v[i].f;
      #1;
      chk($sformatf("v%0d_issue", i), iss, v[i].e_iss);
      chk($sformatf("v%0d_a_rdy", i), a_rdy, v[i].e_iss);
      chk($sformatf("v%0d_b_rdy", i), b_rdy, v[i].e_iss);
      chk($sformatf("v%0d_o_vld", i), o_vld, v[i].e_ovld);
      chk($sformatf("v%0d_wen", i), wen, v[i].e_wen);
      chk($sformatf("v%0d_wten", i), wten, v[i].e_wten);
      chk($sformatf("v%0d_fdone", i), fdone, v[i].e_fd);
      chk($sformatf("v%0d_idle", i), idl, v[i].e_idle);
      chk($sformatf("v%0d_inflight", i), inf, v[i].e_inf);
      chk($sformatf("v%0d_op_cnt", i), cnt, v[i].e_cnt);
      tick();
    end

    // reset with two ops in flight under backpressure
    a_vld = 1'b1;
    b_vld = 1'b1;
    o_rdy = 1'b0;
    #1;
    chk("mid_issue", iss, 1);
    tick();
    a_vld = 1'b0;
    b_vld = 1'b0;
    #1;
    chk("mid_o_vld", o_vld, 1);
    chk("mid_wen", wen, 0);
    chk("mid_inflight", inf, 2);
    chk("mid_op_cnt", cnt, 12);
    rstn = 1'b0;
    tick();
    chk("mrst_o_vld", o_vld, 0);
    chk("mrst_inflight", inf, 0);
    chk("mrst_op_cnt", cnt, 0);
    chk("mrst_idle", idl, 1);
    chk("mrst_wten", wten, 1);
    rstn  = 1'b1;
    o_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mrst_nores%0d", i), o_vld, 0);
      tick();
    end

    // op_cnt wrap after 2^CNTW issues
    a_vld = 1'b1;
    b_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("wrap_issue%0d", i), iss, 1);
      chk($sformatf("wrap_cnt%0d", i), cnt, i);
      chk($sformatf("wrap_inf%0d", i), inf, (i < 3) ? i : 3);
      tick();
    end
    a_vld = 1'b0;
    b_vld = 1'b0;
    #1;
    chk("wrap_cnt_end", cnt, 0);
    chk("wrap_inf_end", inf, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
